apb_slave_regfile: RTL

- APB3 completer (slave) holding a small byte-wide register file; the responder end of the APB link whose initiator side is driven through transfer/READ_WRITE/paddr/wdata.
- Two instances sit behind the APB master, each selected by its own psel.
- Supports a configurable number of wait states and signals out-of-range accesses with pslverr.

---
 rtl/apb_slave_regfile_if.sv | 25 ++
 rtl/apb_slave_regfile.sv | 121 ++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between a requester and a register-file completer.
// The requester drives select, control and write data; the completer returns read data and status.
interface apb_slave_regfile_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a byte-wide register file, programmable wait states and
// pslverr on out-of-range addresses. All outputs are registered.
module apb_slave_regfile #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned WAIT_STATES = 1
) (
    input logic                pclk,
    input logic                preset,
    apb_slave_regfile_if.slave bus
);
    localparam int unsigned IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

    state_e                r_state;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_pready;
    logic                  r_pslverr;

    logic                  w_setup;
    logic                  w_do_op;
    logic                  w_op_write;
    logic [ADDR_WIDTH-1:0] w_op_addr;
    logic [DATA_WIDTH-1:0] w_op_wdata;
    logic [IDX_W-1:0]      w_op_idx;
    logic                  w_in_range;

    // With no wait states the operation fires on the setup edge, so it must use
    // the live bus fields; otherwise it uses the fields latched at setup.
    always_comb begin
        w_setup    = bus.psel && !bus.penable;
        w_do_op    = 1'b0;
        w_op_write = r_write;
        w_op_addr  = r_addr;
        w_op_wdata = r_wdata;
        if (r_state == StIdle) begin
            w_op_write = bus.pwrite;
            w_op_addr  = bus.paddr;
            w_op_wdata = bus.pwdata;
            w_do_op    = w_setup && NO_WAIT;
        end else if (r_state == StWait) begin
            w_do_op = bus.psel && bus.penable && (r_cnt == 4'd1);
        end
        w_op_idx   = w_op_addr[IDX_W-1:0];
        w_in_range = 32'(w_op_addr) < MEM_DEPTH;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_setup) begin
                        r_write <= bus.pwrite;
                        r_addr  <= bus.paddr;
                        r_wdata <= bus.pwdata;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (!bus.psel) begin
                        r_state   <= StIdle;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else if (bus.penable && (r_cnt != 4'd1)) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StAccess: begin
                    r_state   <= StIdle;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase

            // Completing edge: overrides the state chosen above.
            if (w_do_op) begin
                r_state  <= StAccess;
                r_pready <= 1'b1;
                if (w_in_range) begin
                    r_pslverr <= 1'b0;
                    if (w_op_write) begin
                        r_mem[w_op_idx] <= w_op_wdata;
                    end else begin
                        r_prdata <= r_mem[w_op_idx];
                    end
                end else begin
                    r_pslverr <= 1'b1;
                    if (!w_op_write) begin
                        r_prdata <= '0;
                    end
                end
            end
        end
    end

    assign bus.prdata  = r_prdata;
    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
endmodule
